// File: rtl/hex_dump_tx.sv
// Hex-dump serializer: queues {data, nibble count, crlf} requests and streams
// them out as lowercase ASCII hex with group spaces and optional CR LF.
module hex_dump_tx #(
    parameter int DATA_W     = 56,
    parameter int GROUP      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_crlf,
    output logic              tx_valid,
    output logic [7:0]        tx_char,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int MAX_LEN = DATA_W / 4;
    localparam int ENTRY_W = 1 + LEN_W + DATA_W;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] GROUP_L   = LEN_W'(GROUP);
    localparam logic [PTR_W:0]   DEPTH_L   = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NIB  = 3'd1;
    localparam logic [2:0] S_SPC  = 3'd2;
    localparam logic [2:0] S_CR   = 3'd3;
    localparam logic [2:0] S_LF   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W:0]     level;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [LEN_W-1:0]   len_clamped;

    logic [ENTRY_W-1:0] head;
    logic               head_crlf;
    logic [LEN_W-1:0]   head_len;
    logic [DATA_W-1:0]  head_data;

    logic [2:0]         state;
    logic [DATA_W-1:0]  data_r;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_dec;
    logic               crlf_r;
    logic [3:0]         nibble;

    // Pointers carry one extra wrap bit so the difference is the true level.
    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == DEPTH_L);
    assign empty      = (level == '0);
    assign req_ready  = ~full;
    assign push       = req_valid & ~full;
    assign pop        = (state == S_IDLE) & ~empty;
    assign fifo_level = LEN_W'(level);
    assign len_clamped = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;

    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign head_crlf = head[ENTRY_W-1];
    assign head_len  = head[ENTRY_W-2 -: LEN_W];
    assign head_data = head[DATA_W-1:0];

    // NOTE: storage array has no reset; only the pointers define validity,
    // and non-blocking assignments keep read-before-write ordering per edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {req_crlf, len_clamped, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign cnt_dec = cnt - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            data_r <= '0;
            cnt    <= '0;
            crlf_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        data_r <= head_data;
                        cnt    <= head_len;
                        crlf_r <= head_crlf;
                        if (head_len != '0) state <= S_NIB;
                        else if (head_crlf) state <= S_CR;
                        else                state <= S_FIN;
                    end
                end
                S_NIB: begin
                    if (tx_ready) begin
                        cnt <= cnt_dec;
                        if (cnt_dec == '0)                  state <= crlf_r ? S_CR : S_FIN;
                        else if ((cnt_dec % GROUP_L) == '0) state <= S_SPC;
                    end
                end
                S_SPC:   if (tx_ready) state <= S_NIB;
                S_CR:    if (tx_ready) state <= S_LF;
                S_LF:    if (tx_ready) state <= S_FIN;
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (cnt == LEN_W'(i + 1)) nibble = data_r[4*i +: 4];
        end
    end

    always_comb begin
        tx_char = 8'h00;
        case (state)
            S_NIB:   tx_char = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble}
                                                : 8'h57 + {4'h0, nibble};
            S_SPC:   tx_char = 8'h20;
            S_CR:    tx_char = 8'h0d;
            S_LF:    tx_char = 8'h0a;
            default: tx_char = 8'h00;
        endcase
    end

    assign tx_valid = (state == S_NIB) | (state == S_SPC) | (state == S_CR) | (state == S_LF);
    assign done     = (state == S_FIN);
    assign busy     = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_hex_dump_tx.sv
// Directed bench for hex_dump_tx: table of dump requests with expected byte
// strings, plus hand sequences for backpressure, FIFO full and mid-line reset.
module tb_hex_dump_tx;

    localparam int DATA_W     = 56;
    localparam int GROUP      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [LEN_W-1:0]  req_len;
    logic              req_crlf;
    logic              tx_valid;
    logic [7:0]        tx_char;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  fifo_level;

    always #5 clk = ~clk;

    hex_dump_tx #(
        .DATA_W(DATA_W), .GROUP(GROUP), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_len(req_len), .req_crlf(req_crlf),
        .tx_valid(tx_valid), .tx_char(tx_char), .tx_ready(tx_ready),
        .busy(busy), .done(done), .fifo_level(fifo_level)
    );

    typedef struct {
        string             name;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic              crlf;
        string             exp;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    int  done_cnt;
    int  cyc_n;
    int  first_valid_at;
    int  done_at;
    bit  toggle;
    bit  stall_prev;
    logic [7:0] stall_char;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got [%s] expected [%s]", name, act, exp);
        end
    endtask

    function automatic string q_hex();
        string s = "";
        foreach (got[i]) s = {s, $sformatf("%02x", got[i])};
        return s;
    endfunction

    function automatic string s_hex(input string t);
        string s = "";
        for (int i = 0; i < t.len(); i++) s = {s, $sformatf("%02x", t[i])};
        return s;
    endfunction

    // Called at a negedge: observe the cycle about to be clocked, then advance one clock.
    task automatic cyc();
        if (!rst) begin
            if (tx_valid && tx_ready) got.push_back(tx_char);
            if (stall_prev && tx_valid) check("stall_stable", 64'(tx_char), 64'(stall_char));
            stall_prev = tx_valid && !tx_ready;
            stall_char = tx_char;
            if (tx_valid && first_valid_at < 0) first_valid_at = cyc_n;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc_n;
            end
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (toggle) tx_ready = (cyc_n % 3 == 0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l,
                        input logic c, output bit acc);
        req_valid = 1'b1;
        req_data  = d;
        req_len   = l;
        req_crlf  = c;
        acc       = req_ready;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic run_line(input vec_t v, input bit timing);
        bit acc;
        int budget;
        got.delete();
        done_cnt = 0;
        push(v.data, v.len, v.crlf, acc);
        check({v.name, "_accept"}, 64'(acc), 64'(1));
        cyc_n = 0;
        first_valid_at = -1;
        done_at = -1;
        budget = 0;
        while (done_cnt == 0 && budget < 300) begin
            cyc();
            budget++;
        end
        for (int i = 0; i < 3; i++) cyc();
        check_str({v.name, "_bytes"}, q_hex(), s_hex(v.exp));
        check({v.name, "_done_cnt"}, 64'(done_cnt), 64'(1));
        if (timing) begin
            check({v.name, "_first_valid"}, 64'(first_valid_at), 64'((v.exp.len() > 0) ? 1 : -1));
            check({v.name, "_done_at"}, 64'(done_at), 64'(1 + v.exp.len()));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit acc;
        int acc_n;
        int budget;
        logic [DATA_W-1:0] d;

        vecs[0] = '{"full14",  56'h0123456789abcd, 5'd14, 1'b1, "01 23 45 67 89 ab cd\015\012"};
        vecs[1] = '{"abc3",    56'h000000000abc,   5'd3,  1'b0, "a bc"};
        vecs[2] = '{"crlf0",   56'h0,              5'd0,  1'b1, "\015\012"};
        vecs[3] = '{"empty0",  56'h0,              5'd0,  1'b0, ""};
        vecs[4] = '{"clamp20", 56'h0123456789abcd, 5'd20, 1'b0, "01 23 45 67 89 ab cd"};
        vecs[5] = '{"len5",    56'hfedcba98765432, 5'd5,  1'b1, "6 54 32\015\012"};
        vecs[6] = '{"one9",    56'h9,              5'd1,  1'b0, "9"};

        rst = 1'b1;
        req_valid = 1'b0;
        req_data = '0;
        req_len = '0;
        req_crlf = 1'b0;
        tx_ready = 1'b1;
        toggle = 1'b0;
        stall_prev = 1'b0;
        stall_char = 8'h00;
        cyc_n = 0;
        done_cnt = 0;
        first_valid_at = -1;
        done_at = -1;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;

        check("rst_tx_valid",   64'(tx_valid),   64'(0));
        check("rst_tx_char",    64'(tx_char),    64'(0));
        check("rst_done",       64'(done),       64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_fifo_level", 64'(fifo_level), 64'(0));
        check("rst_req_ready",  64'(req_ready),  64'(1));

        // Table: ready held high, exact latency and no bubbles.
        for (int i = 0; i < 7; i++) run_line(vecs[i], 1'b1);

        // Backpressure: ready asserted one cycle in three.
        toggle = 1'b1;
        tx_ready = 1'b0;
        run_line(vecs[0], 1'b0);
        toggle = 1'b0;
        tx_ready = 1'b1;

        // Six back-to-back pushes with the sink stalled.
        tx_ready = 1'b0;
        got.delete();
        done_cnt = 0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            d = DATA_W'((i + 1) * 17);
            push(d, 5'd2, 1'b0, acc);
            if (acc) acc_n++;
            if (i == 5) check("full_push6_ready", 64'(acc), 64'(0));
        end
        check("full_accepted",   64'(acc_n),      64'(5));
        check("full_fifo_level", 64'(fifo_level), 64'(4));
        check("full_req_ready",  64'(req_ready),  64'(0));
        check("full_busy",       64'(busy),       64'(1));
        check("full_tx_valid",   64'(tx_valid),   64'(1));
        tx_ready = 1'b1;
        budget = 0;
        while (done_cnt < 5 && budget < 300) begin
            cyc();
            budget++;
        end
        for (int i = 0; i < 3; i++) cyc();
        check_str("full_bytes", q_hex(), s_hex("1122334455"));
        check("full_done_cnt",    64'(done_cnt),   64'(5));
        check("full_idle_busy",   64'(busy),       64'(0));
        check("full_idle_level",  64'(fifo_level), 64'(0));

        // Reset during the 5th byte of a line with two requests queued.
        tx_ready = 1'b0;
        push(56'h0123456789abcd, 5'd14, 1'b1, acc);
        push(56'h1111, 5'd4, 1'b1, acc);
        push(56'h2222, 5'd4, 1'b1, acc);
        check("mid_fifo_level", 64'(fifo_level), 64'(2));
        tx_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 4; i++) cyc();
        check_str("mid_first4", q_hex(), s_hex("01 2"));
        check("mid_5th_char", 64'(tx_char), 64'(8'h33));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_tx_valid",  64'(tx_valid),   64'(0));
        check("mid_rst_busy",      64'(busy),       64'(0));
        check("mid_rst_level",     64'(fifo_level), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready),  64'(1));
        check("mid_rst_tx_char",   64'(tx_char),    64'(0));
        done_cnt = 0;
        got.delete();
        for (int i = 0; i < 4; i++) cyc();
        check("mid_rst_quiet_bytes", 64'(got.size()), 64'(0));
        check("mid_rst_quiet_done",  64'(done_cnt),   64'(0));
        run_line(vecs[1], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_dump_tx.md
Name: hex_dump_tx

Overview:
- Parametrised hex-dump serializer for the UART monitor transmit path.
- Accepts formatted-dump requests through a small request FIFO: data word, nibble count, CR/LF flag.
- Emits lowercase ASCII hex characters, group-separating spaces and an optional CR LF as a byte stream.
- The byte stream goes to the UART transmit sink under a valid/ready handshake, so CPU-status, memory-dump and echo traffic can queue instead of overwriting each other.

Parameters:
- DATA_W, 56, request data width in bits; multiple of 4, 8..64.
- GROUP, 2, nibbles per space-separated group, counted from the LSB end; 1..16.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, >=2.
- LEN_W, 5, width of req_len; must hold DATA_W/4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept; equals ~fifo_full
- req_data  in  DATA_W  value to print
- req_len  in  LEN_W  nibbles to print, taken from the LSB end; 0 = none
- req_crlf  in  1  append CR (0x0d) then LF (0x0a)
- tx_valid  out  1  tx_char valid
- tx_char  out  8  ASCII byte to transmit
- tx_ready  in  1  sink accepts tx_char this cycle
- busy  out  1  engine active or FIFO non-empty
- done  out  1  one-cycle pulse when a request's last byte is accepted (or when an empty request retires)
- fifo_level  out  LEN_W  entries currently queued (excludes the request in the engine)

Behaviour:
- Reset, applied on any rising clk edge with rst=1, takes effect regardless of state, including mid-request:
  - FIFO cleared, engine IDLE.
  - tx_valid=0, tx_char=8'h00, done=0, busy=0, fifo_level=0.
  - req_ready=1 from the first cycle after reset.
  - An in-flight character is dropped; no partial line is completed.
- Push: on req_valid & req_ready, store {req_crlf, min(req_len, DATA_W/4), req_data}. Clamping is applied at push time.
- Push while full is ignored: req_ready is 0 and nothing is stored. A pop in the same cycle does not make room that cycle.
- Engine states: IDLE, NIB, SPC, CR, LF, FIN.
- IDLE: if the FIFO is non-empty, pop the head into a shift register and nibble counter cnt=len.
  - len>0: go to NIB.
  - len=0 & crlf: go to CR.
  - len=0 & !crlf: go to FIN.
- Latency: a push into an empty FIFO with the engine IDLE at edge k gives the pop at edge k+1 and tx_valid=1 in the cycle after edge k+1.
- NIB:
  - tx_char = hex(data[4*cnt-1 -: 4]); 0-9 map to 0x30-0x39, a-f to 0x61-0x66.
  - On tx_ready: cnt<=cnt-1.
  - If the new cnt is nonzero and a multiple of GROUP: go to SPC.
  - If the new cnt is nonzero and not a multiple of GROUP: stay in NIB.
  - If the new cnt is 0: go to CR if crlf, else FIN.
- SPC: tx_char=0x20; on tx_ready go to NIB.
- CR: tx_char=0x0d; on tx_ready go to LF.
- LF: tx_char=0x0a; on tx_ready go to FIN.
- FIN: done=1 for exactly one cycle, tx_valid=0, then IDLE. A queued request is popped on the following edge, so there is one idle cycle between requests.
- tx_valid=1 exactly in NIB/SPC/CR/LF. tx_char is stable while tx_valid=1 and tx_ready=0. There are no bubbles inside a request when tx_ready is held high.
- Only one byte advances per accepted handshake. tx_ready while tx_valid=0 has no effect.
- busy = (state!=IDLE) | fifo non-empty.
- fifo_level wraps correctly across pointer wrap-around. Simultaneous push and pop leaves the level unchanged.

Test Plan:
- DATA_W=56, GROUP=2: push data 0x0123456789abcd, len=14, crlf=1, tx_ready=1 -> 22 consecutive bytes "01 23 45 67 89 ab cd" then 0d 0a; first byte 2 cycles after push; done one cycle after LF accepted.
- Push data 0xabc, len=3, crlf=0 -> bytes 61 20 62 63 ("a bc"); no CR/LF; done pulse.
- Same as scenario 1 with tx_ready toggled 1-of-3 cycles -> identical byte sequence; tx_char never changes while tx_valid=1 & tx_ready=0.
- tx_ready=0, push 6 requests back-to-back -> 5 accepted (1 in engine + 4 queued), req_ready=0 on the 6th, fifo_level=4. Release tx_ready -> all 5 lines emitted in order.
- Push len=0 crlf=1 -> 0d 0a then done. Push len=0 crlf=0 -> no tx_valid, done pulse 2 cycles after push. Push len=20 -> clamped to 14 nibbles.
- Assert rst during the 5th byte of a line with 2 queued -> next cycle tx_valid=0, busy=0, fifo_level=0, req_ready=1. A new request then prints cleanly from its first nibble.
